// File: rtl/signed_multiply_by_power_of_2_serial.sv
// Serial signed multiply by a power of two.
// Accepts one operand pair, shifts it left one bit per clock while
// tracking signed overflow, then presents a saturated result until the
// consumer takes it. One operation is in flight at a time.
module signed_multiply_by_power_of_2_serial #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  res,
  output logic          overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [N-1:0] w;
  logic [SW-1:0]       count;
  logic                sign;
  logic                v;

  // Clamp to the signed range when the sticky overflow flag is set; the
  // clamp direction follows the sign of the original operand because the
  // working register no longer carries a meaningful sign after overflow.
  function automatic logic signed [N-1:0] saturate(
    input logic                vflag,
    input logic                neg,
    input logic signed [N-1:0] val
  );
    logic signed [N-1:0] max_pos;
    logic signed [N-1:0] max_neg;
    max_pos = {1'b0, {(N-1){1'b1}}};
    max_neg = {1'b1, {(N-1){1'b0}}};
    if (!vflag)
      return val;
    else if (neg)
      return max_neg;
    else
      return max_pos;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic: s == 0 skips SHIFT entirely; count == 1 is the last shift.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (s == '0) ? DONE : SHIFT;
      SHIFT:   if (count == SW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working register, shift counter, captured sign and sticky overflow.
  // Overflow is detected before each shift: if the top two bits differ,
  // the next shift would change the sign bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      w     <= '0;
      count <= '0;
      sign  <= 1'b0;
      v     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w     <= a;
            count <= s;
            sign  <= a[N-1];
            v     <= 1'b0;
          end
        end
        SHIFT: begin
          v     <= v | (w[N-1] ^ w[N-2]);
          w     <= {w[N-2:0], 1'b0};
          count <= count - SW'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake and result outputs; result lines are forced to zero outside DONE.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    res       = '0;
    overflow  = 1'b0;
    if (state == DONE) begin
      res      = saturate(v, sign, w);
      overflow = v;
    end
  end

endmodule

// File: tb/tb_signed_multiply_by_power_of_2_serial.sv
// Directed and randomized bench for signed_multiply_by_power_of_2_serial (N=8, SW=3).
module tb_signed_multiply_by_power_of_2_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [2:0] s = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] res;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  signed_multiply_by_power_of_2_serial #(.N(8), .SW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for exactly one cycle.
  task automatic do_accept(input logic [7:0] av, input logic [2:0] sv);
    a        = av;
    s        = sv;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'h05;
    s        = 3'd0;
    cyc();
    cyc();
    rst      = 1'b0;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (res !== 8'h00) begin bad++; $display("FAIL reset_res: got %h want 00", res); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    cyc();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_in_valid_ignored: got out_valid %b want 0", out_valid); end
  endtask

  // One operation with out_ready held high: checks latency, result, and release.
  task automatic test_op(input string name, input logic [7:0] av, input logic [2:0] sv,
                         input logic [7:0] exp_res, input logic exp_ovf);
    int lat;
    out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_before: got %b want 1", name, in_ready); end
    do_accept(av, sv);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      total++;
      if (res !== 8'h00 || overflow !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s_busy_outputs: got res=%h ovf=%b in_ready=%b want 00/0/0", name, res, overflow, in_ready);
      end
      cyc();
      lat++;
    end
    total++;
    if (lat !== int'(sv) + 1) begin bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, int'(sv) + 1); end
    total++;
    if (res !== exp_res) begin bad++; $display("FAIL %s_res: got %h want %h", name, res, exp_res); end
    total++;
    if (overflow !== exp_ovf) begin bad++; $display("FAIL %s_overflow: got %b want %b", name, overflow, exp_ovf); end
    cyc();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res !== 8'h00) begin
      bad++;
      $display("FAIL %s_release: got out_valid=%b in_ready=%b res=%h want 0/1/00", name, out_valid, in_ready, res);
    end
  endtask

  task automatic test_basic();
    test_op("pos_shift3", 8'h05, 3'd3, 8'h28, 1'b0);
    test_op("neg_shift2", 8'hFB, 3'd2, 8'hEC, 1'b0);
    test_op("zero_shift7", 8'h00, 3'd7, 8'h00, 1'b0);
  endtask

  task automatic test_overflow();
    test_op("ovf_pos", 8'h30, 3'd2, 8'h7F, 1'b1);
    test_op("neg_fit", 8'hC0, 3'd1, 8'h80, 1'b0);
    test_op("ovf_neg", 8'hC0, 3'd2, 8'h80, 1'b1);
    test_op("m1_shift7", 8'hFF, 3'd7, 8'h80, 1'b0);
    test_op("minneg_shift1", 8'h80, 3'd1, 8'h80, 1'b1);
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    do_accept(8'h9A, 3'd0);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_latency: got out_valid %b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || res !== 8'h9A || in_ready !== 1'b0 || overflow !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d: got out_valid=%b res=%h in_ready=%b ovf=%b want 1/9a/0/0",
                 i, out_valid, res, in_ready, overflow);
      end
      if (i == 1) begin
        a        = 8'h01;
        s        = 3'd0;
        in_valid = 1'b1;
      end
      cyc();
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    total++;
    if (res !== 8'h9A) begin bad++; $display("FAIL stall_res_final: got %h want 9a", res); end
    cyc();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    cyc();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_phantom: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_abort();
    out_ready = 1'b1;
    do_accept(8'h11, 3'd5);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res !== 8'h00 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: got out_valid=%b in_ready=%b res=%h ovf=%b want 0/1/00/0",
               out_valid, in_ready, res, overflow);
    end
    test_op("after_abort", 8'h01, 3'd1, 8'h02, 1'b0);
  endtask

  task automatic test_random();
    int ops_done;
    ops_done = 0;
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] av;
      logic [2:0] sv;
      int         p;
      logic [7:0] exp_res;
      logic       exp_ovf;
      int         cnt;
      bit         done;
      av = 8'($urandom);
      sv = 3'($urandom_range(0, 7));
      p  = int'($signed(av)) * (1 << sv);
      exp_ovf = (p > 127) || (p < -128);
      if (p > 127)       exp_res = 8'h7F;
      else if (p < -128) exp_res = 8'h80;
      else               exp_res = p[7:0];
      out_ready = 1'($urandom_range(0, 1));
      for (int k = $urandom_range(0, 2); k > 0; k--) cyc();
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL rand_ready op%0d: got %b want 1", n, in_ready); end
      do_accept(av, sv);
      done = 1'b0;
      cnt  = 0;
      while (!done && cnt < 100) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid === 1'b1) begin
          total++;
          if (res !== exp_res || overflow !== exp_ovf) begin
            bad++;
            $display("FAIL rand_result op%0d a=%h s=%0d: got %h/%b want %h/%b",
                     n, av, sv, res, overflow, exp_res, exp_ovf);
          end
          if (out_ready) done = 1'b1;
        end
        cyc();
        cnt++;
      end
      total++;
      if (!done) begin bad++; $display("FAIL rand_timeout op%0d: got no result want result", n); end
      else ops_done++;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_duplicate op%0d: got out_valid %b want 0", n, out_valid); end
    end
    total++;
    if (ops_done !== 1000) begin bad++; $display("FAIL rand_count: got %0d want 1000", ops_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
